ddr_pair_deserializer: RTL and testbench

//  Downstream consumer of the dual-edge capture flip-flop stage. Each clk cycle it

---
 rtl/ddr_pair_deserializer.sv | 168 ++++++++++++++++
 tb/tb_ddr_pair_deserializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr_pair_deserializer.sv
// Assembles DDR-captured bit pairs into WIDTH-bit words aligned by a sync marker,
// buffering completed words in a 2-entry valid/ready output queue.
module ddr_pair_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             d_rise,
  input  logic             d_fall,
  input  logic             in_sync,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             sync_err,
  output logic             aligned
);

  localparam int PAIRS = WIDTH / 2;
  localparam int CW    = $clog2(PAIRS + 1);

  typedef enum logic {
    IDLE     = 1'b0,
    ASSEMBLE = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [CW-1:0]    slot;
  logic             load;
  logic             word_done;
  logic [WIDTH-1:0] word_reg, word_next;
  logic             sync_err_reg, sync_err_next;

  logic [WIDTH-1:0] head_reg, head_next;
  logic [WIDTH-1:0] tail_reg, tail_next;
  logic             valid_reg, valid_next;
  logic             full_reg, full_next;
  logic             overflow_reg, overflow_next;
  logic             pop;

  // Alignment FSM: decides which pair slot the incoming pair fills.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    sync_err_next = 1'b0;
    load          = 1'b0;
    slot          = '0;
    word_done     = 1'b0;
    if (in_valid) begin
      case (state_reg)
        IDLE: begin
          if (in_sync) begin
            load       = 1'b1;
            state_next = ASSEMBLE;
          end
        end
        ASSEMBLE: begin
          load = 1'b1;
          if (in_sync) begin
            sync_err_next = (count_reg != '0);
          end else begin
            slot = count_reg;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    if (load) begin
      if (slot == CW'(PAIRS - 1)) begin
        word_done  = 1'b1;
        count_next = '0;
      end else begin
        count_next = slot + CW'(1);
      end
    end
  end

  // Every slot is rewritten before a word completes, so stale bits from a
  // discarded partial word never reach the output.
  generate
    for (genvar gi = 0; gi < PAIRS; gi++) begin : gen_pair
      localparam int B0 = MSB_FIRST ? (WIDTH - 1 - 2 * gi) : (2 * gi);
      localparam int B1 = MSB_FIRST ? (WIDTH - 2 - 2 * gi) : (2 * gi + 1);
      logic hit;
      assign hit           = load && (slot == CW'(gi));
      assign word_next[B0] = hit ? d_rise : word_reg[B0];
      assign word_next[B1] = hit ? d_fall : word_reg[B1];
    end
  endgenerate

  assign pop = valid_reg & out_ready;

  // Shift-style 2-entry queue: head_reg drives out_data directly.
  always_comb begin
    head_next     = head_reg;
    tail_next     = tail_reg;
    valid_next    = valid_reg;
    full_next     = full_reg;
    overflow_next = overflow_reg;
    case ({full_reg, valid_reg})
      2'b00: begin
        if (word_done) begin
          head_next  = word_next;
          valid_next = 1'b1;
        end
      end
      2'b01: begin
        if (word_done && pop) begin
          head_next = word_next;
        end else if (pop) begin
          valid_next = 1'b0;
        end else if (word_done) begin
          tail_next = word_next;
          full_next = 1'b1;
        end
      end
      2'b11: begin
        if (pop) begin
          head_next = tail_reg;
          full_next = 1'b0;
          if (word_done) begin
            tail_next = word_next;
            full_next = 1'b1;
          end
        end else if (word_done) begin
          overflow_next = 1'b1;
        end
      end
      default: begin
        full_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      word_reg     <= '0;
      sync_err_reg <= 1'b0;
      head_reg     <= '0;
      tail_reg     <= '0;
      valid_reg    <= 1'b0;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      word_reg     <= word_next;
      sync_err_reg <= sync_err_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      valid_reg    <= valid_next;
      full_reg     <= full_next;
      overflow_reg <= overflow_next;
    end
  end

  assign out_data  = head_reg;
  assign out_valid = valid_reg;
  assign overflow  = overflow_reg;
  assign sync_err  = sync_err_reg;
  assign aligned   = (state_reg == ASSEMBLE);

endmodule

// File: tb/tb_ddr_pair_deserializer.sv
// Scoreboard bench: two DUTs (MSB-first and LSB-first) share one stimulus stream and
// are compared against a bit-queue reference model.
module tb_ddr_pair_deserializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n, in_valid, d_rise, d_fall, in_sync, out_ready;
  logic [W-1:0] m_data, l_data;
  logic m_valid, m_ovf, m_serr, m_al;
  logic l_valid, l_ovf, l_serr, l_al;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          occ;
  bit          bits_q[$];
  logic [W-1:0] exp_m[$];
  logic [W-1:0] exp_l[$];
  bit          al_exp, ovf_exp, serr_exp, rst_seen;

  ddr_pair_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .d_rise(d_rise), .d_fall(d_fall),
    .in_sync(in_sync), .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .overflow(m_ovf), .sync_err(m_serr), .aligned(m_al));

  ddr_pair_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .d_rise(d_rise), .d_fall(d_fall),
    .in_sync(in_sync), .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .overflow(l_ovf), .sync_err(l_serr), .aligned(l_al));

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: stream bits collected per word, occupancy of a 2-deep buffer.
  always @(posedge clk) begin : model
    bit pop, push;
    logic [W-1:0] wm, wl;
    if (!rst_n) begin
      occ = 0; exp_m.delete(); exp_l.delete(); bits_q.delete();
      al_exp = 0; ovf_exp = 0; serr_exp = 0; rst_seen = 1;
    end else begin
      rst_seen = 0;
      serr_exp = 0;
      push = 0;
      wm = '0;
      wl = '0;
      pop = (occ > 0) && out_ready;
      if (in_valid) begin
        if (in_sync) begin
          if (al_exp && bits_q.size() != 0) serr_exp = 1;
          al_exp = 1;
          bits_q.delete();
        end
        if (al_exp) begin
          bits_q.push_back(d_rise);
          bits_q.push_back(d_fall);
          if (bits_q.size() == W) begin
            for (int k = 0; k < W; k++) begin
              wm[W-1-k] = bits_q[k];
              wl[k]     = bits_q[k];
            end
            push = 1;
            bits_q.delete();
          end
        end
      end
      if (push && occ == 2 && !pop) begin
        ovf_exp = 1;
      end else if (push) begin
        exp_m.push_back(wm);
        exp_l.push_back(wl);
        occ = occ + 1;
      end
      if (pop) occ = occ - 1;
    end
  end

  // Monitor: compares flags every cycle and pops the scoreboard on handshakes.
  always @(negedge clk) begin : monitor
    if (rst_n !== 1'bx) begin
      chk("aligned_m", m_al, al_exp);
      chk("aligned_l", l_al, al_exp);
      chk("overflow_m", m_ovf, ovf_exp);
      chk("overflow_l", l_ovf, ovf_exp);
      chk("sync_err_m", m_serr, serr_exp);
      chk("sync_err_l", l_serr, serr_exp);
      chk("out_valid_m", m_valid, occ > 0);
      chk("out_valid_l", l_valid, occ > 0);
      if (rst_seen) begin
        chk("rst_data_m", m_data, 0);
        chk("rst_data_l", l_data, 0);
      end
      if (m_valid && exp_m.size() != 0) begin
        chk("data_m", m_data, exp_m[0]);
        chk("data_l", l_data, exp_l[0]);
        if (out_ready) begin
          void'(exp_m.pop_front());
          void'(exp_l.pop_front());
        end
      end
    end
  end

  task automatic step(input bit v, input bit r, input bit f, input bit s);
    in_valid = v; d_rise = r; d_fall = f; in_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, $urandom_range(1), $urandom_range(1), $urandom_range(1));
  endtask

  // Sends w so that the MSB-first DUT reproduces w.
  task automatic send_word(input logic [W-1:0] w, input bit sync);
    for (int i = 0; i < W / 2; i++) step(1, w[W-1-2*i], w[W-2-2*i], sync && i == 0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    for (int i = 0; i < n; i++) step($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1));
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; d_rise = 0; d_fall = 0; in_sync = 0; out_ready = 0;

    // T1 reset with random inputs
    out_ready = $urandom_range(1);
    do_reset(2);
    chk("t1_valid", m_valid, 0);
    chk("t1_aligned", m_al, 0);
    out_ready = 1;

    // T2 basic word
    step(1, 1, 0, 1); step(1, 1, 1, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    chk("t2_msb", m_data, 8'hB2);
    chk("t2_lsb", l_data, 8'h4D);
    chk("t2_valid", m_valid, 1);
    idle(1);
    chk("t2_valid_drop", m_valid, 0);

    // T3 pre-sync discard
    do_reset(1);
    for (int i = 0; i < 3; i++) step(1, $urandom_range(1), $urandom_range(1), 0);
    chk("t3_not_aligned", m_al, 0);
    step(1, 1, 0, 1);
    chk("t3_aligned", m_al, 1);
    step(1, 1, 1, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    chk("t3_word", m_data, 8'hB2);
    idle(2);

    // T4 resync with partial word pending
    step(1, 0, 1, 1); step(1, 1, 1, 0);
    step(1, 1, 0, 1);
    chk("t4_sync_err", m_serr, 1);
    step(1, 1, 1, 0);
    chk("t4_sync_err_once", m_serr, 0);
    step(1, 0, 0, 0); step(1, 1, 0, 0);
    chk("t4_word", m_data, 8'hB2);
    idle(2);

    // T5 backpressure and overflow
    out_ready = 0;
    send_word(8'hA5, 1); send_word(8'h3C, 0); send_word(8'hF0, 0);
    chk("t5_overflow", m_ovf, 1);
    chk("t5_head", m_data, 8'hA5);
    out_ready = 1;
    idle(1);
    chk("t5_second", m_data, 8'h3C);
    idle(3);
    chk("t5_ovf_sticky", m_ovf, 1);

    // T6 full + pop on completing cycle, then mid-word reset
    do_reset(1);
    out_ready = 0;
    send_word(8'h11, 1); send_word(8'h22, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0);
    out_ready = 1;
    step(1, 0, 1, 0);
    chk("t6_no_overflow", m_ovf, 0);
    idle(4);
    step(1, 1, 0, 1); step(1, 0, 1, 0);
    do_reset(1);
    idle(6);
    chk("t6_aligned", m_al, 0);
    chk("t6_valid", m_valid, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(400) == 0) do_reset(1);
      else step($urandom_range(3) != 0, $urandom_range(1), $urandom_range(1), $urandom_range(9) == 0);
    end
    out_ready = 1;
    idle(8);
    chk("drain_empty", exp_m.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
